// File: rtl/div_32bit_seq_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface div_32bit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             ready;
  logic             div_by_zero;
  logic             ovf;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, ready, div_by_zero, ovf
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, ready, div_by_zero, ovf
  );
endinterface

// File: rtl/div_32bit_seq.sv
// Multicycle signed divider: restoring shift-and-subtract on magnitudes,
// one quotient bit per clock, sign fix-up in a final cycle.
module div_32bit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  div_32bit_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] prem;      // partial remainder magnitude
  logic [WIDTH-1:0] dvd_mag;   // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dsr_mag;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic             ovf_pend;

  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    abs_dvd = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    abs_dsr = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
    shifted = {prem, dvd_mag[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_mag};
  end

  // Control FSM, working registers and registered results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      prem            <= '0;
      dvd_mag         <= '0;
      dsr_mag         <= '0;
      count           <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      ovf_pend        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.ready       <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.ready <= 1'b0;
          if (bus.start) begin
            sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r   <= bus.dividend[WIDTH-1];
            ovf_pend <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
            dvd_mag  <= abs_dvd;
            dsr_mag  <= abs_dsr;
            prem     <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= (bus.divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            prem    <= trial[WIDTH-1:0];
            dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b1};
          end else begin
            prem    <= shifted[WIDTH-1:0];
            dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST_ITER) state <= FIX;
        end
        FIX: begin
          // MOST_NEG / -1 falls out naturally: magnitude 2^(WIDTH-1), positive sign.
          bus.quotient    <= sign_q ? (~dvd_mag + 1'b1) : dvd_mag;
          bus.remainder   <= sign_r ? (~prem + 1'b1) : prem;
          bus.ovf         <= ovf_pend;
          bus.div_by_zero <= 1'b0;
          bus.ready       <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        DONE: begin
          // Re-applying the dividend sign to its magnitude restores the raw dividend.
          bus.quotient    <= '0;
          bus.remainder   <= sign_r ? (~dvd_mag + 1'b1) : dvd_mag;
          bus.ovf         <= 1'b0;
          bus.div_by_zero <= 1'b1;
          bus.ready       <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit_seq.sv
// Self-checking bench for div_32bit_seq using a scoreboard of expected results.
module tb_div_32bit_seq;

  logic clock = 1'b0;
  logic reset;

  div_32bit_seq_if #(.WIDTH(32)) bus ();

  div_32bit_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      e.q = 32'd0; e.r = a; e.dz = 1'b1; e.ov = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.dz = 1'b0; e.ov = 1'b1;
    end else begin
      e.q = sa / sb; e.r = sa % sb; e.dz = 1'b0; e.ov = 1'b0;
    end
    return e;
  endfunction

  // Drive one start pulse at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sbq.push_back(model(a, b));
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Bounded wait for ready, sampling on falling edges.
  task automatic wait_ready(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (bus.ready !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcyc++;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.ready, bus.div_by_zero, bus.ovf} !== 68'd0) begin
      bad++;
      $display("FAIL reset_state: got q=%h r=%h busy=%b ready=%b dz=%b ov=%b want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.ready, bus.div_by_zero, bus.ovf);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    int   cyc, bcyc;
    exp_t e;
    issue(32'd100, 32'd7);
    wait_ready(cyc, bcyc);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL basic_latency: got %0d want 33", cyc); end
    total++;
    if (bcyc !== 33) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 33", bcyc); end
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b ov=%b want q=14 r=2 dz=0 ov=0",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf);
    end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL basic_sb: got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
    end
    @(negedge clock);
    total++;
    if ({bus.ready, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL ready_pulse: got ready=%b busy=%b want 0 0", bus.ready, bus.busy);
    end
  endtask

  task automatic test_signs;
    logic [31:0] ops [4][2];
    int   cyc, bcyc;
    exp_t e;
    ops[0][0] = -32'sd100; ops[0][1] = 32'd7;
    ops[1][0] = 32'd100;   ops[1][1] = -32'sd7;
    ops[2][0] = -32'sd100; ops[2][1] = -32'sd7;
    ops[3][0] = 32'h8000_0000; ops[3][1] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i][0], ops[i][1]);
      wait_ready(cyc, bcyc);
      total++;
      if (cyc !== 33) begin bad++; $display("FAIL sign_latency[%0d]: got %0d want 33", i, cyc); end
      e = sbq.pop_front();
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
        bad++;
        $display("FAIL sign_result[%0d]: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b", i,
                 bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf, e.q, e.r, e.dz, e.ov);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_overflow;
    int   cyc, bcyc;
    exp_t e;
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(cyc, bcyc);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL ovf_latency: got %0d want 33", cyc); end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL ovf_result: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf, e.q, e.r, e.dz, e.ov);
    end
    @(negedge clock);
  endtask

  task automatic test_div_zero;
    int   cyc, bcyc;
    exp_t e;
    issue(32'd12345, 32'd0);
    wait_ready(cyc, bcyc);
    total++;
    if (cyc !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", cyc); end
    total++;
    if (bcyc !== 1) begin bad++; $display("FAIL dz_busy_cycles: got %0d want 1", bcyc); end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf, e.q, e.r, e.dz, e.ov);
    end
    @(negedge clock);
  endtask

  task automatic test_start_ignored;
    int   cyc, bcyc;
    exp_t e;
    issue(32'd1000, 32'd33);
    repeat (9) @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd55;
    bus.divisor  = 32'd5;
    @(negedge clock);
    bus.start = 1'b0;
    wait_ready(cyc, bcyc);
    total++;
    if (cyc + 10 !== 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", cyc + 10); end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL ignore_result: got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int   cyc, bcyc;
    exp_t e;
    issue(-32'sd77777, 32'd123);
    wait_ready(cyc, bcyc);
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL b2b_first: got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
    end
    issue(32'd987654, -32'sd321);
    total++;
    if ({bus.ready, bus.busy} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_accept: got ready=%b busy=%b want 0 1", bus.ready, bus.busy);
    end
    wait_ready(cyc, bcyc);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      bad++;
      $display("FAIL b2b_second: got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midrun;
    int   cyc, bcyc;
    bit   saw_ready;
    exp_t e;
    issue(32'd5000, 32'd3);
    repeat (19) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.ready, bus.div_by_zero, bus.ovf} !== 68'd0) begin
      bad++;
      $display("FAIL async_reset: got q=%h r=%h busy=%b ready=%b dz=%b ov=%b want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.ready, bus.div_by_zero, bus.ovf);
    end
    void'(sbq.pop_back());
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 2) reset = 1'b0;
      if (bus.ready === 1'b1 || bus.busy === 1'b1) saw_ready = 1'b1;
    end
    total++;
    if (saw_ready !== 1'b0) begin bad++; $display("FAIL reset_discard: got activity=1 want 0"); end
    issue(32'd7, 32'd7);
    wait_ready(cyc, bcyc);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL post_reset_latency: got %0d want 33", cyc); end
    e = sbq.pop_front();
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {32'd1, 32'd0, 1'b0, 1'b0}
        || e.q !== 32'd1) begin
      bad++;
      $display("FAIL post_reset_7_7: got q=%h r=%h want q=1 r=0", bus.quotient, bus.remainder);
    end
    @(negedge clock);
  endtask

  task automatic test_random;
    int          cyc, bcyc;
    logic [31:0] a, b;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : {{22{1'b0}}, 10'($urandom_range(1, 1000))};
      if (i % 4 == 1) b = ~b + 1'b1;
      issue(a, b);
      wait_ready(cyc, bcyc);
      total++;
      if (cyc !== ((b == 32'd0) ? 1 : 33)) begin
        bad++;
        $display("FAIL rand_latency[%0d]: got %0d", i, cyc);
      end
      e = sbq.pop_front();
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf} !== {e.q, e.r, e.dz, e.ov}) begin
        bad++;
        $display("FAIL rand_result[%0d] %h/%h: got q=%h r=%h want q=%h r=%h", i, a, b,
                 bus.quotient, bus.remainder, e.q, e.r);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset        = 1'b1;
    test_reset;
    test_basic;
    test_signs;
    test_overflow;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_32bit_seq.md
Name: div_32bit_seq

Overview:
- Multicycle signed integer divider for the datapath's divide operation.
- Uses iterative shift-and-subtract (non-restoring not required; restoring is acceptable), one quotient bit per clock.
- Sits beside the single-cycle 32-bit adder in the ALU/multdiv path.
- Uses a start/ready handshake so the pipeline can stall while the division runs.

Parameters:
WIDTH, 32, operand/result width in bits; all latency numbers below scale as WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on a rising edge only while busy=0
dividend  input  WIDTH  signed two's-complement dividend, sampled with start
divisor  input  WIDTH  signed two's-complement divisor, sampled with start
quotient  output  WIDTH  signed quotient, registered
remainder  output  WIDTH  signed remainder, registered
busy  output  1  high from the edge after start is accepted until the edge that raises ready
ready  output  1  one-cycle pulse: results valid
div_by_zero  output  1  result flag: divisor was 0
ovf  output  1  result flag: dividend=-2^(WIDTH-1) and divisor=-1

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - quotient=0, remainder=0, busy=0, ready=0, div_by_zero=0, ovf=0.
  - Any in-flight operation is discarded; no ready follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with start=1, capture the operands.
  - Store sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Load the unsigned magnitudes |dividend| and |divisor|, WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1) with no error.
  - Clear the partial remainder and set the iteration counter to 0.
  - If divisor==0, go to DONE; otherwise go to RUN.
  - busy=1 from this edge.
- RUN, once per edge:
  - Shift {partial_rem, dividend_mag} left by 1.
  - Trial-subtract divisor_mag from the WIDTH+1-bit partial_rem.
  - If the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set bit 0.
  - Increment the counter. After exactly WIDTH iterations, go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -q_mag : q_mag, and remainder = sign_r ? -r_mag : r_mag.
  - ovf=1 iff dividend==-2^(WIDTH-1) and divisor==-1; quotient is then 0x80000000 (wraps) and remainder=0.
  - div_by_zero=0. ready=1, busy=0, go to IDLE.
- DONE (divide by zero), one edge:
  - quotient=0, remainder=dividend (as captured), div_by_zero=1, ovf=0.
  - ready=1, busy=0, go to IDLE.
- Latency:
  - Normal case: ready is high in the cycle after edge E(WIDTH+1), where E0 is the start-sampling edge (33 edges for WIDTH=32).
  - Divide by zero: ready is high after E1.
- ready is a single-cycle pulse and deasserts on the next edge regardless of start.
- quotient, remainder, div_by_zero and ovf hold their values until the next FIX/DONE or reset.
- They are not modified during RUN; internal working registers are separate from the outputs.
- start while busy=1 is ignored, and operands are not re-sampled.
- start=1 in the same cycle ready=1 is accepted, since the state is already IDLE. The new operation begins and ready drops next edge.
- Semantics: truncation toward zero. Identity dividend = quotient*divisor + remainder (mod 2^WIDTH). |remainder| < |divisor|, and remainder has the sign of the dividend or is 0.

Test Plan:
- Reset, then start with dividend=100, divisor=7 -> after 33 edges, ready pulse for 1 cycle; quotient=14, remainder=2, flags 0. busy high for exactly 33 cycles.
- Signs: -100/7 -> q=-14 (0xFFFFFFF2), r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
- dividend=0x80000000, divisor=0xFFFFFFFF -> q=0x80000000, r=0, ovf=1. Also 0x80000000/1 -> q=0x80000000, r=0, ovf=0.
- dividend=12345, divisor=0 -> ready after 1 edge; q=0, r=12345, div_by_zero=1, no RUN cycles.
- Pulse start again at cycle 10 of an operation with different operands -> ignored; first result unchanged. Start coincident with ready -> second result 33 edges later.
- Assert reset at cycle 20 of a run -> all outputs 0 immediately (asynchronously), no ready. A subsequent 7/7 -> q=1, r=0.
